// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/stop configuration encodings, receiver states and helpers.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage bit synchroniser for asynchronous inputs; flops reset to 1 (idle-high lines).
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8 data bits, none/even/odd/unchecked parity, 1 or 2 stop bits).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (one clock later).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        mclk,
    input  logic        n_reset,
    input  logic [15:0] baud_max_cnt,
    input  logic [1:0]  parity_sel,
    input  logic        stop_sel,
    input  logic        rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    logic      rxd_s;
    logic      rxd_prev_q;
    logic      fall;
    logic      start_hit;
    logic      data_hit;
    logic      bit_val;
    logic [15:0] half;

    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] baud_q, baud_d;
    logic [1:0]  psel_q, psel_d;
    logic        stop2_q, stop2_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        perr_acc_q, perr_acc_d;
    logic        ferr_acc_q, ferr_acc_d;
    logic        stopcnt_q, stopcnt_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (mclk),
        .rst_ni(n_reset),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    assign fall     = ~rxd_s & rxd_prev_q;
    assign half     = baud_q >> 1;
    assign data_hit = (cnt_q == baud_q);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    // Deciding at half+1 and restarting cnt there keeps every later decision at bit offset half+1.
    assign start_hit = (cnt_q == half + 16'd1);
    assign bit_val   = maj3(rxd_s, hist_q[0], hist_q[1]);
`else
    assign start_hit = (cnt_q == half);
    assign bit_val   = rxd_s;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        baud_d       = baud_q;
        psel_d       = psel_q;
        stop2_d      = stop2_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        stopcnt_d    = stopcnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    baud_d  = baud_max_cnt;
                    psel_d  = parity_sel;
                    stop2_d = stop_sel;
                    state_d = START;
                end
            end
            START: begin
                if (start_hit) begin
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    state_d  = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (data_hit) begin
                    cnt_d    = '0;
                    shreg_d  = {bit_val, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'(DATA_BITS - 1)) begin
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                        stopcnt_d  = 1'b0;
                        state_d    = (psel_q == PAR_NONE) ? STOP : PARITY;
                    end
                end
            end
            PARITY: begin
                if (data_hit) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (psel_q == PAR_EVEN) begin
                        perr_acc_d = (bit_val != ^shreg_q);
                    end else if (psel_q == PAR_ODD) begin
                        perr_acc_d = (bit_val != ~^shreg_q);
                    end
                end
            end
            STOP: begin
                if (data_hit) begin
                    cnt_d = '0;
                    if ((stop2_q == STOP_2) && !stopcnt_q) begin
                        stopcnt_d  = 1'b1;
                        ferr_acc_d = ferr_acc_q | ~bit_val;
                    end else begin
                        state_d      = IDLE;
                        rx_valid_d   = 1'b1;
                        rx_data_d    = shreg_q;
                        parity_err_d = perr_acc_q;
                        frame_err_d  = ferr_acc_q | ~bit_val;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            rxd_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            baud_q       <= '0;
            psel_q       <= PAR_NONE;
            stop2_q      <= STOP_1;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            stopcnt_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rxd_prev_q   <= rxd_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            baud_q       <= baud_d;
            psel_q       <= psel_d;
            stop2_q      <= stop2_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            stopcnt_q    <= stopcnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled bit by bit, expectations queued at drive time.
module tb_uart_rx;
    import uart_pkg::*;

    logic        mclk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] baud_max_cnt = 16'd15;
    logic [1:0]  parity_sel = PAR_NONE;
    logic        stop_sel = STOP_1;
    logic        rxd = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned valid_cnt = 0;
    int unsigned busy_cnt = 0;

    always #5 mclk = ~mclk;

    uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .mclk        (mclk),
        .n_reset     (n_reset),
        .baud_max_cnt(baud_max_cnt),
        .parity_sel  (parity_sel),
        .stop_sel    (stop_sel),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge mclk);
            if (busy) busy_cnt++;
            if (rx_valid) begin
                valid_cnt++;
                chk("valid_pulse_width", 32'(prev_v), 32'd0);
                if (sb.size() == 0) begin
                    chk("spurious_valid_sb_depth", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.d));
                    chk("parity_err", 32'(parity_err), 32'(e.pe));
                    chk("frame_err", 32'(frame_err), 32'(e.fe));
                    chk("busy_on_valid", 32'(busy), 32'd0);
                end
            end
            prev_v = rx_valid;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (32'(baud_max_cnt) + 1) @(negedge mclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop1, input logic stop2);
        exp_t e;
        logic pbit;
        pbit = (parity_sel == PAR_EVEN) ? ^d : (parity_sel == PAR_ODD) ? ~^d : 1'b0;
        e.d  = d;
        e.pe = par_flip && (parity_sel == PAR_EVEN || parity_sel == PAR_ODD);
        e.fe = !stop1 || ((stop_sel == STOP_2) && !stop2);
        sb.push_back(e);
        drive_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) drive_bit(d[i]);
        if (parity_sel != PAR_NONE) drive_bit(pbit ^ par_flip);
        drive_bit(stop1);
        if (stop_sel == STOP_2) drive_bit(stop2);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic drain(input string tag);
        for (int unsigned i = 0; i < 2000 && sb.size() != 0; i++) @(negedge mclk);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v0;
        int unsigned b0;
        logic [7:0] f0;
        logic [7:0] bytes_a [3];
        bytes_a = '{8'h00, 8'hFF, 8'h55};
        f0 = 8'hF0;

        fork
            monitor();
        join_none

        repeat (3) @(negedge mclk);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        n_reset = 1'b1;
        repeat (5) @(negedge mclk);

        v0 = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        drain("drain_a5");
        chk("a5_valid_count", valid_cnt - v0, 32'd1);
        chk("a5_busy_after", 32'(busy), 32'd0);

        parity_sel = PAR_EVEN;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        drain("drain_parity");

        parity_sel = PAR_NONE;
        stop_sel   = STOP_2;
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
        drain("drain_stop2");

        stop_sel = STOP_1;
        b0 = busy_cnt;
        v0 = valid_cnt;
        rxd = 1'b0;
        repeat (4) @(negedge mclk);
        rxd = 1'b1;
        repeat (40) @(negedge mclk);
        chk("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
        chk("glitch_no_valid", valid_cnt - v0, 32'd0);
        chk("glitch_busy_after", 32'(busy), 32'd0);

        drive_bit(1'b0);
        for (int unsigned i = 0; i < 4; i++) drive_bit(f0[i]);
        n_reset = 1'b0;
        repeat (2) @(negedge mclk);
        chk("abort_rx_data", 32'(rx_data), 32'd0);
        chk("abort_rx_valid", 32'(rx_valid), 32'd0);
        chk("abort_parity_err", 32'(parity_err), 32'd0);
        chk("abort_frame_err", 32'(frame_err), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge mclk);
        n_reset = 1'b1;
        repeat (20) @(negedge mclk);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        drain("drain_after_abort");

        // Break: a held-low line yields one all-zero frame with a framing error, then nothing.
        v0 = valid_cnt;
        sb.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
        rxd = 1'b0;
        repeat (16 * 16) @(negedge mclk);
        rxd = 1'b1;
        repeat (64) @(negedge mclk);
        chk("break_valid_count", valid_cnt - v0, 32'd1);
        drain("drain_break");
        send_frame(8'h42, 1'b0, 1'b1, 1'b1);
        drain("drain_after_break");

        baud_max_cnt = 16'd40;
        for (int unsigned p = 0; p < 4; p++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                parity_sel = 2'(p);
                stop_sel   = 1'(s);
                for (int unsigned k = 0; k < 3; k++) send_frame(bytes_a[k], 1'b0, 1'b1, 1'b1);
            end
        end
        drain("drain_sweep");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
